tlc_phase_scheduler: RTL and testbench

Phase scheduler for the highway/farm-road intersection: shares the crossing between the highway (default owner), farm-road vehicle requests and pedestrian requests, with an emergency preempt that returns right-of-way to the highway. It owns all phase timing through a tick prescaler and per-phase down-counter, and drives the one-hot light encodings consumed by the top-level pin mapping.

---
 rtl/tlc_pkg.sv | 40 ++++
 rtl/tlc_phase_scheduler_if.sv | 23 ++
 rtl/tlc_tick_prescaler.sv | 27 ++
 rtl/tlc_phase_scheduler.sv | 178 +++++++++++++++++
 tb/tb_tlc_phase_scheduler.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/tlc_pkg.sv
// Shared types and constants for the intersection phase scheduler:
// phase codes, one-hot light encodings, grant type and light decode helpers.
package tlc_pkg;

  typedef enum logic [2:0] {
    HWY_GREEN   = 3'd0,
    HWY_YELLOW  = 3'd1,
    ALL_RED     = 3'd2,
    FARM_GREEN  = 3'd3,
    FARM_YELLOW = 3'd4,
    WALK        = 3'd5
  } phase_t;

  typedef enum logic [1:0] {
    GRANT_HWY  = 2'd0,
    GRANT_FARM = 2'd1,
    GRANT_PED  = 2'd2
  } grant_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  function automatic logic [2:0] hwy_light_of(input phase_t p);
    case (p)
      HWY_GREEN:  return GRN;
      HWY_YELLOW: return YEL;
      default:    return RED;
    endcase
  endfunction

  function automatic logic [2:0] farm_light_of(input phase_t p);
    case (p)
      FARM_GREEN:  return GRN;
      FARM_YELLOW: return YEL;
      default:     return RED;
    endcase
  endfunction

endpackage

// File: rtl/tlc_phase_scheduler_if.sv
// Request inputs and light/phase outputs of the phase scheduler.
// The scheduler uses the slave view; the environment drives through master.
interface tlc_phase_scheduler_if;
  logic       farm_req;
  logic       ped_req;
  logic       emg;
  logic [2:0] hwy_light;
  logic [2:0] farm_light;
  logic       walk;
  logic [2:0] phase;
  logic       farm_ack;
  logic       ped_ack;

  modport master (
    output farm_req, ped_req, emg,
    input  hwy_light, farm_light, walk, phase, farm_ack, ped_ack
  );

  modport slave (
    input  farm_req, ped_req, emg,
    output hwy_light, farm_light, walk, phase, farm_ack, ped_ack
  );
endinterface

// File: rtl/tlc_tick_prescaler.sv
// Divides clk into one-cycle timing ticks; clr restarts the count so every
// phase starts on a fresh tick boundary.
module tlc_tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [15:0] count_r;

  assign tick = (count_r == 16'(TICK_DIV - 1));

  // Prescale counter: wraps on tick, restarts on phase entry
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 16'd0;
    end else if (clr || tick) begin
      count_r <= 16'd0;
    end else begin
      count_r <= count_r + 16'd1;
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Highway/farm-road phase scheduler: phase FSM, per-phase down-counter,
// request pending/arbitration and emergency preempt back to the highway.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int T_HG     = 3,
  parameter int T_Y      = 2,
  parameter int T_AR     = 1,
  parameter int T_FG     = 5,
  parameter int T_WALK   = 4
) (
  input logic                  clk,
  input logic                  rst,
  tlc_phase_scheduler_if.slave bus
);

  phase_t     phase_r, phase_s;
  grant_t     dest_r, dest_s, grant_s, last_grant_r;
  logic [7:0] timer_r;
  logic       mg_done_r, farm_pend_r, ped_pend_r;
  logic       farm_ack_r, ped_ack_r, walk_r;
  logic [2:0] hwy_light_r, farm_light_r;
  logic       tick_s, expire_s, enter_s;

  function automatic logic [7:0] load_of(input phase_t p);
    case (p)
      HWY_YELLOW, FARM_YELLOW: return 8'(T_Y - 1);
      ALL_RED:                 return 8'(T_AR - 1);
      FARM_GREEN:              return 8'(T_FG - 1);
      WALK:                    return 8'(T_WALK - 1);
      default:                 return 8'(T_HG - 1);
    endcase
  endfunction

  tlc_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (enter_s),
    .tick (tick_s)
  );

  assign expire_s = tick_s && (timer_r == 8'd0);
  assign enter_s  = (phase_s != phase_r);

  // Arbitration: on a tie, serve whichever side was not granted last
  always_comb begin
    grant_s = GRANT_HWY;
    if (farm_pend_r && ped_pend_r) begin
      grant_s = (last_grant_r == GRANT_FARM) ? GRANT_PED : GRANT_FARM;
    end else if (farm_pend_r) begin
      grant_s = GRANT_FARM;
    end else if (ped_pend_r) begin
      grant_s = GRANT_PED;
    end else begin
      grant_s = GRANT_HWY;
    end
  end

  // Next phase and destination; emg only ever shortens green or walk
  always_comb begin
    phase_s = phase_r;
    dest_s  = dest_r;
    case (phase_r)
      HWY_GREEN: begin
        if ((mg_done_r || expire_s) && (farm_pend_r || ped_pend_r) && !bus.emg) begin
          phase_s = HWY_YELLOW;
          dest_s  = grant_s;
        end else begin
          phase_s = HWY_GREEN;
        end
      end
      HWY_YELLOW: begin
        if (bus.emg) begin
          dest_s = GRANT_HWY;
        end else begin
          dest_s = dest_r;
        end
        if (expire_s) begin
          phase_s = ALL_RED;
        end else begin
          phase_s = HWY_YELLOW;
        end
      end
      ALL_RED: begin
        if (expire_s) begin
          dest_s = GRANT_HWY;
          case (dest_r)
            GRANT_FARM: phase_s = FARM_GREEN;
            GRANT_PED:  phase_s = WALK;
            default:    phase_s = HWY_GREEN;
          endcase
        end else begin
          phase_s = ALL_RED;
        end
      end
      FARM_GREEN: begin
        if (expire_s || bus.emg) begin
          phase_s = FARM_YELLOW;
          dest_s  = GRANT_HWY;
        end else begin
          phase_s = FARM_GREEN;
        end
      end
      FARM_YELLOW: begin
        if (expire_s) begin
          phase_s = ALL_RED;
        end else begin
          phase_s = FARM_YELLOW;
        end
      end
      WALK: begin
        if (expire_s || bus.emg) begin
          phase_s = ALL_RED;
          dest_s  = GRANT_HWY;
        end else begin
          phase_s = WALK;
        end
      end
      default: begin
        phase_s = HWY_GREEN;
        dest_s  = GRANT_HWY;
      end
    endcase
  end

  // State, timer, pending flags and registered lamp outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r      <= HWY_GREEN;
      dest_r       <= GRANT_HWY;
      last_grant_r <= GRANT_PED;
      timer_r      <= 8'(T_HG - 1);
      mg_done_r    <= 1'b0;
      farm_pend_r  <= 1'b0;
      ped_pend_r   <= 1'b0;
      farm_ack_r   <= 1'b0;
      ped_ack_r    <= 1'b0;
      walk_r       <= 1'b0;
      hwy_light_r  <= GRN;
      farm_light_r <= RED;
    end else begin
      phase_r <= phase_s;
      dest_r  <= dest_s;
      if (enter_s) begin
        timer_r <= load_of(phase_s);
      end else if (tick_s && (timer_r != 8'd0)) begin
        timer_r <= timer_r - 8'd1;
      end
      if (enter_s) begin
        mg_done_r <= 1'b0;
      end else if ((phase_r == HWY_GREEN) && expire_s) begin
        mg_done_r <= 1'b1;
      end
      // The ack flags mark the service entry cycle; clearing there beats a set
      farm_pend_r <= farm_ack_r ? 1'b0 : (farm_pend_r | bus.farm_req);
      ped_pend_r  <= ped_ack_r  ? 1'b0 : (ped_pend_r  | bus.ped_req);
      if (farm_ack_r) begin
        last_grant_r <= GRANT_FARM;
      end else if (ped_ack_r) begin
        last_grant_r <= GRANT_PED;
      end
      farm_ack_r   <= enter_s && (phase_s == FARM_GREEN);
      ped_ack_r    <= enter_s && (phase_s == WALK);
      walk_r       <= (phase_s == WALK);
      hwy_light_r  <= hwy_light_of(phase_s);
      farm_light_r <= farm_light_of(phase_s);
    end
  end

  assign bus.phase      = phase_r;
  assign bus.hwy_light  = hwy_light_r;
  assign bus.farm_light = farm_light_r;
  assign bus.walk       = walk_r;
  assign bus.farm_ack   = farm_ack_r;
  assign bus.ped_ack    = ped_ack_r;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed, table-driven bench for tlc_phase_scheduler at default parameters.
// Cycle 0 is the first cycle after reset release; requests are sampled at the end of their cycle.
module tb_tlc_phase_scheduler;
  import tlc_pkg::*;

  typedef struct packed {
    logic [2:0] ph;
    logic [2:0] hwy;
    logic [2:0] farm;
    logic       walk;
    logic       fa;
    logic       pa;
  } smp_t;

  typedef struct {
    int   scen;
    int   cyc;
    smp_t exp;
  } vec_t;

  typedef struct {
    int f_on, f_off, p_on, p_off, e_on, e_off, ncyc;
  } scen_t;

  logic  clk;
  logic  rst;
  int    checks;
  int    failures;
  smp_t  obs [0:127];
  vec_t  vq[$];
  scen_t sc [0:5];

  tlc_phase_scheduler_if bus ();

  tlc_phase_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic smp_t sample();
    return {bus.phase, bus.hwy_light, bus.farm_light, bus.walk, bus.farm_ack, bus.ped_ack};
  endfunction

  // Expected outputs built from the phase/light table
  function automatic smp_t expect_of(input logic [2:0] ph, input logic fa, input logic pa);
    smp_t e;
    e.ph = ph; e.fa = fa; e.pa = pa; e.walk = 1'b0;
    e.hwy = 3'b100; e.farm = 3'b100;
    case (ph)
      3'd0:    e.hwy  = 3'b001;
      3'd1:    e.hwy  = 3'b010;
      3'd3:    e.farm = 3'b001;
      3'd4:    e.farm = 3'b010;
      3'd5:    e.walk = 1'b1;
      default: e.walk = 1'b0;
    endcase
    return e;
  endfunction

  task automatic add(input int s, input int c, input logic [2:0] ph, input logic fa, input logic pa);
    vec_t v;
    v.scen = s; v.cyc = c; v.exp = expect_of(ph, fa, pa);
    vq.push_back(v);
  endtask

  task automatic check(input string name, input smp_t act, input smp_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.farm_req = 1'b0; bus.ped_req = 1'b0; bus.emg = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_scen(input int s);
    do_reset();
    for (int c = 0; c < sc[s].ncyc; c++) begin
      bus.farm_req = (c >= sc[s].f_on) && (c <= sc[s].f_off);
      bus.ped_req  = (c >= sc[s].p_on) && (c <= sc[s].p_off);
      bus.emg      = (c >= sc[s].e_on) && (c <= sc[s].e_off);
      @(negedge clk);
      obs[c] = sample();
      @(posedge clk);
      #1;
    end
    bus.farm_req = 1'b0; bus.ped_req = 1'b0; bus.emg = 1'b0;
  endtask

  initial begin
    smp_t s0;
    logic held;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.farm_req = 1'b0; bus.ped_req = 1'b0; bus.emg = 1'b0;

    // {farm on/off, ped on/off, emg on/off, cycles}; -1 means never
    sc[0] = '{-1, -1, -1, -1, -1, -1, 100};
    sc[1] = '{ 2,  2, -1, -1, -1, -1,  60};
    sc[2] = '{-1, -1, 28, 28, -1, -1,  64};
    sc[3] = '{ 5,  5,  5,  5, -1, -1, 102};
    sc[4] = '{ 2,  2, 35, 35, 30, 79,  96};
    sc[5] = '{ 2, 30, -1, -1, -1, -1,  84};

    add(0, 0, 3'd0, 1'b0, 1'b0);  add(0, 11, 3'd0, 1'b0, 1'b0);
    add(0, 12, 3'd0, 1'b0, 1'b0); add(0, 99, 3'd0, 1'b0, 1'b0);
    add(1, 11, 3'd0, 1'b0, 1'b0); add(1, 12, 3'd1, 1'b0, 1'b0);
    add(1, 19, 3'd1, 1'b0, 1'b0); add(1, 20, 3'd2, 1'b0, 1'b0);
    add(1, 23, 3'd2, 1'b0, 1'b0); add(1, 24, 3'd3, 1'b1, 1'b0);
    add(1, 25, 3'd3, 1'b0, 1'b0); add(1, 43, 3'd3, 1'b0, 1'b0);
    add(1, 44, 3'd4, 1'b0, 1'b0); add(1, 52, 3'd2, 1'b0, 1'b0);
    add(1, 56, 3'd0, 1'b0, 1'b0);
    add(2, 29, 3'd0, 1'b0, 1'b0); add(2, 30, 3'd1, 1'b0, 1'b0);
    add(2, 38, 3'd2, 1'b0, 1'b0); add(2, 42, 3'd5, 1'b0, 1'b1);
    add(2, 43, 3'd5, 1'b0, 1'b0); add(2, 57, 3'd5, 1'b0, 1'b0);
    add(2, 58, 3'd2, 1'b0, 1'b0); add(2, 62, 3'd0, 1'b0, 1'b0);
    add(3, 12, 3'd1, 1'b0, 1'b0); add(3, 24, 3'd3, 1'b1, 1'b0);
    add(3, 44, 3'd4, 1'b0, 1'b0); add(3, 56, 3'd0, 1'b0, 1'b0);
    add(3, 67, 3'd0, 1'b0, 1'b0); add(3, 68, 3'd1, 1'b0, 1'b0);
    add(3, 76, 3'd2, 1'b0, 1'b0); add(3, 80, 3'd5, 1'b0, 1'b1);
    add(3, 96, 3'd2, 1'b0, 1'b0); add(3, 100, 3'd0, 1'b0, 1'b0);
    add(4, 30, 3'd3, 1'b0, 1'b0); add(4, 31, 3'd4, 1'b0, 1'b0);
    add(4, 38, 3'd4, 1'b0, 1'b0); add(4, 39, 3'd2, 1'b0, 1'b0);
    add(4, 43, 3'd0, 1'b0, 1'b0); add(4, 60, 3'd0, 1'b0, 1'b0);
    add(4, 80, 3'd0, 1'b0, 1'b0); add(4, 81, 3'd1, 1'b0, 1'b0);
    add(4, 89, 3'd2, 1'b0, 1'b0); add(4, 93, 3'd5, 1'b0, 1'b1);
    add(5, 24, 3'd3, 1'b1, 1'b0); add(5, 56, 3'd0, 1'b0, 1'b0);
    add(5, 67, 3'd0, 1'b0, 1'b0); add(5, 68, 3'd1, 1'b0, 1'b0);
    add(5, 80, 3'd3, 1'b1, 1'b0); add(5, 81, 3'd3, 1'b0, 1'b0);

    for (int s = 0; s < 6; s++) begin
      run_scen(s);
      for (int i = 0; i < vq.size(); i++) begin
        if (vq[i].scen == s) begin
          check($sformatf("scen%0d_cyc%0d", s, vq[i].cyc), obs[vq[i].cyc], vq[i].exp);
        end
      end
      if (s == 0) begin
        held = 1'b1;
        for (int c = 0; c < 100; c++) begin
          if (obs[c] !== expect_of(3'd0, 1'b0, 1'b0)) held = 1'b0;
        end
        check("idle_hold", {11'd0, held}, {11'd0, 1'b1});
      end
    end

    // Reset during WALK with a farm request pending: everything drops back to HG
    do_reset();
    for (int c = 0; c <= 50; c++) begin
      bus.ped_req  = (c == 28);
      bus.farm_req = (c == 45);
      rst          = (c == 50);
      @(negedge clk);
      if (c == 44) check("walk_before_rst", sample(), expect_of(3'd5, 1'b0, 1'b0));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    bus.farm_req = 1'b0; bus.ped_req = 1'b0;
    @(negedge clk);
    check("rst_in_walk", sample(), expect_of(3'd0, 1'b0, 1'b0));
    held = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.phase !== 3'd0) held = 1'b0;
    end
    check("pend_lost_after_rst", {11'd0, held}, {11'd0, 1'b1});

    // Illegal phase code recovers to HWY_GREEN on the next cycle
    @(negedge clk);
    force dut.phase_r = phase_t'(3'd7);
    #1;
    s0 = expect_of(3'd0, 1'b0, 1'b0);
    s0.ph = 3'd7;
    check("forced_illegal", sample(), s0);
    release dut.phase_r;
    @(negedge clk);
    check("illegal_recover", sample(), expect_of(3'd0, 1'b0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
